// File: rtl/serial_adder6_pkg.sv
// Shared definitions for the bit-serial adder: state encodings and default operand width.
package serial_adder6_pkg;

    localparam int unsigned DEF_WIDTH = 6;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

endpackage

// File: rtl/full_adder1.sv
// Combinational 1-bit full adder; the only arithmetic cell of the serial adder.
module full_adder1 (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    always_comb begin
        p    = a ^ b;
        s    = p ^ cin;
        cout = (a & b) | (cin & p);
    end

endmodule

// File: rtl/serial_adder6.sv
// Bit-serial handshaked unsigned adder: one operand bit per clock through a single full adder,
// WIDTH+1-bit sum returned over a valid/ready channel.
module serial_adder6
    import serial_adder6_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic [CNT_W-1:0] ops_done
);

    localparam int unsigned BW = $clog2(WIDTH + 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [BW-1:0]    bit_cnt;
    logic             fa_s;
    logic             fa_c;

    full_adder1 u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_c)
    );

    // Handshake flags come from registered state only.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            carry    <= 1'b0;
            bit_cnt  <= '0;
            sum      <= '0;
            ops_done <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        carry   <= 1'b0;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Result bits enter from the top so bit 0 lands in place after WIDTH shifts.
                    sum[WIDTH-1:0] <= {fa_s, sum[WIDTH-1:1]};
                    a_sh           <= a_sh >> 1;
                    b_sh           <= b_sh >> 1;
                    carry          <= fa_c;
                    bit_cnt        <= bit_cnt + BW'(1);
                    if (bit_cnt == BW'(WIDTH - 1)) begin
                        sum[WIDTH] <= fa_c;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        ops_done <= ops_done + CNT_W'(1);
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
